// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (pixel divider, X/Y counters, active flag, syncs, frame strobes).
// Latency: every output is registered from the next counter values, so it changes on the advance edge itself.
// Backpressure: none; free-running raster, strobes are single-Clk pulses and are never held off.
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         asynchronous active-high reset; parks the raster on its last position
//   CounterX      current pixel column, 0..H_TOTAL-1
//   CounterY      current line, 0..V_TOTAL-1
//   inDisplayArea high while (CounterX,CounterY) is inside the visible area
//   hsync/vsync   active-low sync pulses for the connector
//   PixelEn       one-Clk pulse in the first cycle a new position is shown
//   FrameStart    pulse with PixelEn when the raster lands on (0,0)
//   VBlankStart   pulse with PixelEn when the raster lands on (0,V_ACTIVE)
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       Clk,
   input  logic       Reset,
   output logic [9:0] CounterX,
   output logic [9:0] CounterY,
   output logic       inDisplayArea,
   output logic       hsync,
   output logic       vsync,
   output logic       PixelEn,
   output logic       FrameStart,
   output logic       VBlankStart
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // A divide-by-one build still needs a one-bit divider register.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);

   // Sync window bounds can reach 1024, so they are compared in 11 bits.
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS_W  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   generate
      if (H_TOTAL > 1024) begin : g_h_total_chk
         $error("vga_timing_gen: H_TOTAL exceeds 1024");
      end
      if (V_TOTAL > 1024) begin : g_v_total_chk
         $error("vga_timing_gen: V_TOTAL exceeds 1024");
      end
      if (CLK_DIV < 1) begin : g_div_chk
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
   endgenerate

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_x;
   logic [9:0]       r_y;
   logic             r_de;
   logic             r_hs;
   logic             r_vs;
   logic             r_pe;
   logic             r_fs;
   logic             r_vb;

   logic             w_adv;
   logic [DIV_W-1:0] w_div_nxt;
   logic             w_x_last;
   logic             w_y_last;
   logic [9:0]       w_x_nxt;
   logic [9:0]       w_y_nxt;
   logic [10:0]      w_x_ext;
   logic [10:0]      w_y_ext;

   assign w_adv     = (r_div == DIV_LAST);
   assign w_div_nxt = w_adv ? '0 : r_div + 1'b1;

   assign w_x_last  = (r_x == H_LAST);
   assign w_y_last  = (r_y == V_LAST);
   assign w_x_nxt   = w_x_last ? 10'd0 : r_x + 10'd1;
   // Y only moves on the X wrap; both wrap together at the last raster position.
   assign w_y_nxt   = w_x_last ? (w_y_last ? 10'd0 : r_y + 10'd1) : r_y;

   assign w_x_ext   = {1'b0, w_x_nxt};
   assign w_y_ext   = {1'b0, w_y_nxt};

   // Flags are computed from the next position so they never lag the counters.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_div <= '0;
         r_x   <= H_LAST;
         r_y   <= V_LAST;
         r_de  <= 1'b0;
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
         r_pe  <= 1'b0;
         r_fs  <= 1'b0;
         r_vb  <= 1'b0;
      end else begin
         r_div <= w_div_nxt;
         r_pe  <= w_adv;
         r_fs  <= w_adv && (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
         r_vb  <= w_adv && (w_x_nxt == 10'd0) && (w_y_nxt == V_VIS);
         if (w_adv) begin
            r_x  <= w_x_nxt;
            r_y  <= w_y_nxt;
            r_de <= (w_x_ext < H_VIS) && (w_y_ext < V_VIS_W);
            r_hs <= !((w_x_ext >= HS_START) && (w_x_ext < HS_END));
            r_vs <= !((w_y_ext >= VS_START) && (w_y_ext < VS_END));
         end
      end
   end

   assign CounterX      = r_x;
   assign CounterY      = r_y;
   assign inDisplayArea = r_de;
   assign hsync         = r_hs;
   assign vsync         = r_vs;
   assign PixelEn       = r_pe;
   assign FrameStart    = r_fs;
   assign VBlankStart   = r_vb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks the raster generator on a full-size build (line 0), a reduced
// raster (whole frames, mid-frame reset) and a reduced divide-by-one build.
// Expected raster points are queued before each reset release; a monitor pops them by pixel index.
module tb_vga_timing_gen;

   typedef struct {
      int    idx;
      string nm;
      int    x;
      int    y;
      bit    de;
      bit    hs;
      bit    vs;
      bit    fs;
      bit    vb;
   } exp_t;

   logic       clk = 1'b0;
   logic [2:0] rst = 3'b000;

   logic [9:0] cx [3];
   logic [9:0] cy [3];
   logic       de [3];
   logic       hs [3];
   logic       vs [3];
   logic       pe [3];
   logic       fs [3];
   logic       vb [3];

   int n_checks = 0;
   int n_fail   = 0;

   int pix [3] = '{0, 0, 0};
   int cyc [3] = '{0, 0, 0};
   int div [3] = '{2, 2, 1};

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   // full-size line-0 hsync low time
   int hs0_low = 0;
   // reduced raster, first frame accumulators
   bit in_f1 = 0;
   bit f1_done = 0;
   int f1_cyc = 0, f1_vslow = 0, f1_pe = 0, f1_ide = 0, f1_fs = 0, f1_vb = 0;
   // divide-by-one build
   int gaps2 = 0;
   int fs2_a = -1, fs2_b = -1;

   always #5 clk = ~clk;

   vga_timing_gen u_full (
      .Clk(clk), .Reset(rst[0]), .CounterX(cx[0]), .CounterY(cy[0]),
      .inDisplayArea(de[0]), .hsync(hs[0]), .vsync(vs[0]),
      .PixelEn(pe[0]), .FrameStart(fs[0]), .VBlankStart(vb[0])
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_small (
      .Clk(clk), .Reset(rst[1]), .CounterX(cx[1]), .CounterY(cy[1]),
      .inDisplayArea(de[1]), .hsync(hs[1]), .vsync(vs[1]),
      .PixelEn(pe[1]), .FrameStart(fs[1]), .VBlankStart(vb[1])
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_div1 (
      .Clk(clk), .Reset(rst[2]), .CounterX(cx[2]), .CounterY(cy[2]),
      .inDisplayArea(de[2]), .hsync(hs[2]), .vsync(vs[2]),
      .PixelEn(pe[2]), .FrameStart(fs[2]), .VBlankStart(vb[2])
   );

   function automatic exp_t mk(input int idx, input string nm, input int x, input int y,
                               input bit e_de, input bit e_hs, input bit e_vs,
                               input bit e_fs, input bit e_vb);
      exp_t e;
      e.idx = idx; e.nm = nm; e.x = x; e.y = y;
      e.de = e_de; e.hs = e_hs; e.vs = e_vs; e.fs = e_fs; e.vb = e_vb;
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_pix(input int d, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                          input logic a_de, input logic a_hs, input logic a_vs,
                          input logic a_fs, input logic a_vb);
      n_checks++;
      if (x !== 10'(e.x) || y !== 10'(e.y) || a_de !== e.de || a_hs !== e.hs ||
          a_vs !== e.vs || a_fs !== e.fs || a_vb !== e.vb) begin
         n_fail++;
         $display("FAIL dut%0d %s: got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b vb=%b, expected x=%0d y=%0d de=%b hs=%b vs=%b fs=%b vb=%b",
                  d, e.nm, x, y, a_de, a_hs, a_vs, a_fs, a_vb,
                  e.x, e.y, e.de, e.hs, e.vs, e.fs, e.vb);
      end
   endtask

   task automatic wait_pix(input int d, input int target, input int budget);
      int n = 0;
      while (pix[d] < target && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk($sformatf("dut%0d_reach_pixel_%0d", d, target), (pix[d] >= target) ? 1 : 0, 1);
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst[i]) cyc[i] = 0;
         else        cyc[i] = cyc[i] + 1;
      end
   end

   // Monitor: every PixelEn pulse is one displayed pixel; pop any checkpoint for that index.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      for (int i = 0; i < 3; i++) begin
         if (rst[i]) begin
            pix[i] = 0;
         end else begin
            if ((fs[i] || vb[i]) && !pe[i]) begin
               n_fail++;
               $display("FAIL dut%0d_strobe_without_pixelen: fs=%b vb=%b pe=%b, expected strobes low", i, fs[i], vb[i], pe[i]);
            end
            if (i == 0 && cy[0] == 10'd0 && !hs[0]) hs0_low++;
            if (i == 1) begin
               if (pe[1] && pix[1] == 150) begin
                  if (in_f1) f1_done = 1;
                  in_f1 = 0;
               end
               if (pe[1] && pix[1] == 0 && !f1_done) in_f1 = 1;
               if (in_f1) begin
                  f1_cyc++;
                  if (!vs[1]) f1_vslow++;
                  if (pe[1]) begin
                     f1_pe++;
                     if (de[1]) f1_ide++;
                     if (fs[1]) f1_fs++;
                     if (vb[1]) f1_vb++;
                  end
               end
            end
            if (i == 2) begin
               if (pix[2] > 0 && !pe[2]) gaps2++;
               if (pe[2] && fs[2]) begin
                  if (fs2_a < 0)      fs2_a = cyc[2];
                  else if (fs2_b < 0) fs2_b = cyc[2];
               end
            end
            if (pe[i]) begin
               if (pix[i] == 0) chk($sformatf("dut%0d_first_advance_edge", i), cyc[i], div[i]);
               if (pix[i] == 1) chk($sformatf("dut%0d_second_advance_edge", i), cyc[i], 2 * div[i]);
               have = 0;
               case (i)
                  0: if (q0.size() > 0 && q0[0].idx == pix[i]) begin e = q0.pop_front(); have = 1; end
                  1: if (q1.size() > 0 && q1[0].idx == pix[i]) begin e = q1.pop_front(); have = 1; end
                  default: if (q2.size() > 0 && q2[0].idx == pix[i]) begin e = q2.pop_front(); have = 1; end
               endcase
               if (have) cmp_pix(i, e, cx[i], cy[i], de[i], hs[i], vs[i], fs[i], vb[i]);
               pix[i] = pix[i] + 1;
            end
         end
      end
   end

   initial begin
      #1 rst = 3'b111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      cmp_pix(0, mk(-1, "reset_state", 799, 524, 0, 1, 1, 0, 0), cx[0], cy[0], de[0], hs[0], vs[0], fs[0], vb[0]);
      chk("dut0_reset_pixelen", pe[0], 0);
      cmp_pix(1, mk(-1, "reset_state", 14, 9, 0, 1, 1, 0, 0), cx[1], cy[1], de[1], hs[1], vs[1], fs[1], vb[1]);

      // Full-size build, line 0 and the start of line 1.
      q0.push_back(mk(0,   "px0_frame_start", 0,   0, 1, 1, 1, 1, 0));
      q0.push_back(mk(1,   "px1",             1,   0, 1, 1, 1, 0, 0));
      q0.push_back(mk(639, "last_visible",    639, 0, 1, 1, 1, 0, 0));
      q0.push_back(mk(640, "first_hblank",    640, 0, 0, 1, 1, 0, 0));
      q0.push_back(mk(655, "before_hsync",    655, 0, 0, 1, 1, 0, 0));
      q0.push_back(mk(656, "hsync_first",     656, 0, 0, 0, 1, 0, 0));
      q0.push_back(mk(751, "hsync_last",      751, 0, 0, 0, 1, 0, 0));
      q0.push_back(mk(752, "after_hsync",     752, 0, 0, 1, 1, 0, 0));
      q0.push_back(mk(799, "line_end",        799, 0, 0, 1, 1, 0, 0));
      q0.push_back(mk(800, "line1_start",     0,   1, 1, 1, 1, 0, 0));
      @(negedge clk);
      #2 rst[0] = 1'b0;
      wait_pix(0, 801, 2000);
      chk("dut0_hsync_low_clk_line0", hs0_low, 192);

      // Reduced raster: 15x10 positions, hsync X=10..12, vsync Y=7..8, vblank at Y=6.
      q1.push_back(mk(0,   "frame_start",  0,  0, 1, 1, 1, 1, 0));
      q1.push_back(mk(7,   "last_visible", 7,  0, 1, 1, 1, 0, 0));
      q1.push_back(mk(8,   "first_hblank", 8,  0, 0, 1, 1, 0, 0));
      q1.push_back(mk(9,   "before_hsync", 9,  0, 0, 1, 1, 0, 0));
      q1.push_back(mk(10,  "hsync_first",  10, 0, 0, 0, 1, 0, 0));
      q1.push_back(mk(12,  "hsync_last",   12, 0, 0, 0, 1, 0, 0));
      q1.push_back(mk(13,  "after_hsync",  13, 0, 0, 1, 1, 0, 0));
      q1.push_back(mk(14,  "line_end",     14, 0, 0, 1, 1, 0, 0));
      q1.push_back(mk(15,  "line1_start",  0,  1, 1, 1, 1, 0, 0));
      q1.push_back(mk(89,  "last_vis_line_end", 14, 5, 0, 1, 1, 0, 0));
      q1.push_back(mk(90,  "vblank_start", 0,  6, 0, 1, 1, 0, 1));
      q1.push_back(mk(104, "before_vsync", 14, 6, 0, 1, 1, 0, 0));
      q1.push_back(mk(105, "vsync_first",  0,  7, 0, 1, 0, 0, 0));
      q1.push_back(mk(134, "vsync_last",   14, 8, 0, 1, 0, 0, 0));
      q1.push_back(mk(135, "after_vsync",  0,  9, 0, 1, 1, 0, 0));
      q1.push_back(mk(149, "frame_end",    14, 9, 0, 1, 1, 0, 0));
      q1.push_back(mk(150, "frame2_start", 0,  0, 1, 1, 1, 1, 0));
      q1.push_back(mk(151, "frame2_px1",   1,  0, 1, 1, 1, 0, 0));
      @(negedge clk);
      #2 rst[1] = 1'b0;
      wait_pix(1, 201, 600);
      chk("dut1_frame_clk_cycles",   f1_cyc,   300);
      chk("dut1_frame_pixelen",      f1_pe,    150);
      chk("dut1_frame_visible_px",   f1_ide,   48);
      chk("dut1_frame_framestart",   f1_fs,    1);
      chk("dut1_frame_vblankstart",  f1_vb,    1);
      chk("dut1_frame_vsync_low_clk", f1_vslow, 60);

      // Asynchronous reset between edges at (5,3) of the second frame.
      chk("dut1_pre_reset_x", cx[1], 5);
      chk("dut1_pre_reset_y", cy[1], 3);
      rst[1] = 1'b1;
      #1;
      cmp_pix(1, mk(-1, "async_reset", 14, 9, 0, 1, 1, 0, 0), cx[1], cy[1], de[1], hs[1], vs[1], fs[1], vb[1]);
      chk("dut1_async_reset_pixelen", pe[1], 0);
      repeat (2) @(negedge clk);
      q1.push_back(mk(0, "restart_frame_start", 0, 0, 1, 1, 1, 1, 0));
      q1.push_back(mk(1, "restart_px1",         1, 0, 1, 1, 1, 0, 0));
      #2 rst[1] = 1'b0;
      wait_pix(1, 2, 50);

      // Divide-by-one build.
      q2.push_back(mk(0,   "frame_start",  0, 0, 1, 1, 1, 1, 0));
      q2.push_back(mk(1,   "px1",          1, 0, 1, 1, 1, 0, 0));
      q2.push_back(mk(15,  "line1_start",  0, 1, 1, 1, 1, 0, 0));
      q2.push_back(mk(90,  "vblank_start", 0, 6, 0, 1, 1, 0, 1));
      q2.push_back(mk(150, "frame2_start", 0, 0, 1, 1, 1, 1, 0));
      @(negedge clk);
      #2 rst[2] = 1'b0;
      wait_pix(2, 301, 400);
      chk("dut2_pixelen_gaps", gaps2, 0);
      chk("dut2_framestart_period_clk", fs2_b - fs2_a, 150);

      chk("dut0_checkpoints_left", q0.size(), 0);
      chk("dut1_checkpoints_left", q1.size(), 0);
      chk("dut2_checkpoints_left", q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
